fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//   Drain stage directly downstream of the sync FIFO: pops DATA_WIDTH words whenever the
//   FIFO is non-empty and packs PACK consecutive words into one wide beat on a
//   valid/ready master port. A flush request emits any partial beat with a lane-keep
//   mask, closing a transfer toward the wide-datapath consumer of the accelerator.
// PARAMETERS
//   DATA_WIDTH  32  width of one FIFO word
//   PACK        4   words per output beat (>=2); output width = DATA_WIDTH*PACK
// PORTS
//   clk         in   1              single clock, all logic on rising edge
//   rst         in   1              synchronous, active-high reset
//   fifo_empty  in   1              FIFO empty flag
//   fifo_r_en   out  1              FIFO pop strobe (one word per high cycle)
//   fifo_data   in   DATA_WIDTH     FIFO read data, valid the cycle after fifo_r_en high
//   flush       in   1              request: emit partial beat, pulse flush_done
//   m_valid     out  1              output beat valid
//   m_ready     in   1              downstream accepts beat when m_valid&&m_ready
//   m_data      out  DATA_WIDTH*PACK  packed beat; word k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   m_keep      out  PACK           lane k valid
//   m_last      out  1              beat closes a flush
//   flush_done  out  1              one-cycle pulse, flush complete
// BEHAVIOUR
//   - Reset: fifo_r_en, m_valid, m_last, flush_done = 0; m_data, m_keep = 0; fill_cnt=0,
//     pending read, flush_pending cleared. Data of a read in flight at reset is discarded.
//   - fifo_r_en is combinational: !fifo_empty && !flush_pending && (fill_cnt+pending < PACK
//     || pack completes and transfers at this edge). Never high during rst.
//   - pending = fifo_r_en of previous cycle; word captured into lane fill_cnt that edge.
//   - Word completing lane PACK-1 transfers to output register at the same edge if output
//     empty or m_ready high; else pack reg holds full (fill_cnt=PACK) until output frees.
//   - Output register: m_valid stays high, m_data/m_keep/m_last stable until m_valid&&m_ready.
//     Full beats: m_keep all ones, m_last=0.
//   - Latency: first r_en in cycle 0 (empty pipeline) -> m_valid high in cycle PACK+1.
//     Throughput with fifo non-empty and m_ready=1: one word/cycle, one beat per PACK cycles.
//   - Flush FSM: IDLE -> DRAIN on flush (flush ignored outside IDLE). DRAIN: no new reads;
//     waits for pending word. Then if fill_cnt>0: EMIT -> move partial beat when output
//     free, m_keep=(1<<fill_cnt)-1, unused lanes zero, m_last=1. If fill_cnt==0: no beat.
//     If pending word completes pack during DRAIN it is a full beat with m_last=1.
//     flush_done pulses the cycle after the partial/final beat loads (or after DRAIN
//     resolves with nothing to emit); FSM returns to IDLE the same cycle.
//   - flush and word capture in same cycle: word included in the flushed beat.
//   - fill_cnt never exceeds PACK; no overflow of output register by construction.
// TESTING (DATA_WIDTH=32, PACK=4)
//   1. FIFO holds 8 words 0x1..0x8, m_ready=1 -> beats 0x00000004_00000003_00000002_00000001
//      then ..._8_7_6_5, keep=4'hF, last=0; fifo_r_en high 8 consecutive cycles; first m_valid cycle 5.
//   2. 4 words loaded, m_ready=0 for 10 cycles -> m_valid held, m_data stable; 4 more words
//      pack then r_en stops (fill_cnt=4); m_ready=1 -> both beats in order, no loss/dup.
//   3. 3 words 0xA,0xB,0xC then flush -> one beat keep=4'h7, lane3=0, m_last=1;
//      flush_done pulse one cycle after load; no fifo_r_en during DRAIN.
//   4. flush with empty pack reg and no pending read -> no beat, flush_done pulses next cycle.
//   5. rst asserted mid-pack (2 words captured, 1 pending) -> next cycle all outputs 0;
//      after release, 4 fresh words form a clean beat with no stale lanes.
//   6. fifo_empty toggled randomly, m_ready random 50% -> scoreboard: word order preserved,
//      fifo_r_en never high when fifo_empty=1.

Source files
------------

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops words from the upstream FIFO and packs PACK of them
// into one wide valid/ready beat; a flush emits any partial beat with a keep mask.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   fifo_empty, fifo_r_en FIFO status in / pop strobe out (combinational)
//   fifo_data             FIFO read data, valid the cycle after fifo_r_en
//   flush, flush_done     close request in / one-cycle completion pulse out
//   m_valid, m_ready      output handshake
//   m_data, m_keep        packed beat (lane k at k*DATA_WIDTH) and lane-valid mask
//   m_last                beat closes a flush
module fifo_word_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    output logic                       fifo_r_en,
    input  logic [DATA_WIDTH-1:0]      fifo_data,
    input  logic                       flush,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       m_last,
    output logic                       flush_done
);

    localparam int CW = $clog2(PACK + 1);
    localparam logic [CW:0] PACK_L = (CW + 1)'(PACK);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] fill_cnt, fill_nxt;
    logic          pending;
    logic [CW:0]   level;
    logic          out_free;
    logic          load;
    logic          load_last;
    logic          done_nxt;

    logic [PACK-1:0][DATA_WIDTH-1:0] pack_q, cur, beat;
    logic [PACK-1:0]                 keep_nxt;

    // cur: pack register with the in-flight word merged into its lane.
    // level: words held once that word lands (never exceeds PACK).
    always_comb begin
        out_free = !m_valid || m_ready;
        level    = {1'b0, fill_cnt} + (CW + 1)'(pending);
        cur      = pack_q;
        for (int k = 0; k < PACK; k++) begin
            if (pending && fill_cnt == CW'(k)) begin
                cur[k] = fifo_data;
            end
        end
        for (int k = 0; k < PACK; k++) begin
            keep_nxt[k] = (CW + 1)'(k) < level;
            beat[k]     = keep_nxt[k] ? cur[k] : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = level[CW-1:0];
        fifo_r_en = 1'b0;
        load      = 1'b0;
        load_last = 1'b0;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                // A read may be issued into a full pack only if that
                // pack leaves for the output register at this same edge.
                fifo_r_en = !rst && !fifo_empty &&
                            (level < PACK_L || out_free);
                if (level == PACK_L && out_free) begin
                    load     = 1'b1;
                    fill_nxt = '0;
                end
                if (flush) begin
                    if (!fifo_r_en && fill_nxt == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last in-flight word lands here; no new reads.
                if (level == '0) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_free) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    fill_nxt  = '0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            pending    <= 1'b0;
            pack_q     <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_cnt   <= fill_nxt;
            pending    <= fifo_r_en;
            pack_q     <= cur;
            flush_done <= done_nxt;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= beat;
                m_keep  <= keep_nxt;
                m_last  <= load_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: table-driven flush cases, hand-written corner sequences
// and a randomized run scored against a word-list reference for fifo_word_packer.
module tb_fifo_word_packer;

    localparam int DW = 32;
    localparam int PK = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            fifo_empty = 1'b1;
    logic            fifo_r_en;
    logic [DW-1:0]   fifo_data = '0;
    logic            flush = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [DW*PK-1:0] m_data;
    logic [PK-1:0]   m_keep;
    logic            m_last;
    logic            flush_done;

    fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*PK-1:0] d;
        logic [PK-1:0]    k;
        logic             l;
    } beat_t;

    typedef struct {
        int           n;
        int           nbeats;
        logic [PK-1:0] keep;
        logic          last;
    } vec_t;

    logic [DW-1:0] fifo_mem[$];
    int            rd_ptr = 0;
    logic          pop_now = 1'b0;
    logic          gate_empty = 1'b0;
    beat_t         beats[$];
    int            ren_viol = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    // Behavioural FIFO: data appears the cycle after the pop strobe.
    always @(negedge clk) pop_now = fifo_r_en;

    always @(posedge clk) begin
        if (pop_now && rd_ptr < fifo_mem.size()) begin
            fifo_data <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        fifo_empty = gate_empty || (rd_ptr >= fifo_mem.size());
    end

    always @(negedge clk) begin
        if (fifo_r_en && (fifo_empty || rst)) ren_viol++;
        if (!rst && m_valid && m_ready) begin
            beats.push_back('{m_data, m_keep, m_last});
        end
    end

    task automatic chk(input string nm, input logic [DW*PK-1:0] got,
                       input logic [DW*PK-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_mem.push_back(w);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = flush_done;
        end
        chk(nm, seen, 1'b1);
        tick();
    endtask

    // Reference: beats are consecutive groups of PK words in push order,
    // lanes beyond the word count are zero and masked off.
    task automatic check_beats(input string nm, input int wb, input int nw,
                               input int bb, input logic lastf);
        int nb;
        int got_n;
        logic [DW*PK-1:0] d;
        logic [PK-1:0] k;
        nb = (nw + PK - 1) / PK;
        got_n = beats.size() - bb;
        chk({nm, "_count"}, got_n, nb);
        for (int j = 0; j < nb && j < got_n; j++) begin
            d = '0;
            k = '0;
            for (int ln = 0; ln < PK; ln++) begin
                if (j * PK + ln < nw) begin
                    d[ln*DW +: DW] = fifo_mem[wb + j*PK + ln];
                    k[ln] = 1'b1;
                end
            end
            chk($sformatf("%s_data%0d", nm, j), beats[bb+j].d, d);
            chk($sformatf("%s_keep%0d", nm, j), beats[bb+j].k, k);
            chk($sformatf("%s_last%0d", nm, j), beats[bb+j].l,
                (j == nb - 1) ? lastf : 1'b0);
        end
    endtask

    initial begin
        vec_t tbl[6];
        int wb;
        int bb;
        int ren_first;
        int mv_first;
        int ren_cnt;
        int run;
        int maxrun;
        int ren_drain;
        logic stable;
        logic seen;
        logic [DW*PK-1:0] d0;
        logic [DW*PK-1:0] exp1;

        tbl[0] = '{1, 1, 4'h1, 1'b1};
        tbl[1] = '{2, 1, 4'h3, 1'b1};
        tbl[2] = '{3, 1, 4'h7, 1'b1};
        tbl[3] = '{4, 1, 4'hF, 1'b0};
        tbl[4] = '{5, 2, 4'h1, 1'b1};
        tbl[5] = '{8, 2, 4'hF, 1'b0};

        // reset state
        do_reset();
        @(negedge clk);
        chk("rst_r_en", fifo_r_en, 1'b0);
        chk("rst_valid", m_valid, 1'b0);
        chk("rst_data", m_data, '0);
        chk("rst_keep", m_keep, '0);
        chk("rst_last", m_last, 1'b0);
        chk("rst_done", flush_done, 1'b0);

        // streaming 8 words, latency and throughput
        do_reset();
        m_ready = 1'b1;
        wb = fifo_mem.size();
        bb = beats.size();
        for (int i = 1; i <= 8; i++) push(i);
        ren_first = -1;
        mv_first = -1;
        ren_cnt = 0;
        run = 0;
        maxrun = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fifo_r_en) begin
                ren_cnt++;
                run++;
                if (ren_first < 0) ren_first = i;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
            if (m_valid && mv_first < 0) mv_first = i;
        end
        chk("t1_ren_count", ren_cnt, 8);
        chk("t1_ren_run", maxrun, 8);
        chk("t1_latency", mv_first - ren_first, 5);
        exp1 = 128'h00000004_00000003_00000002_00000001;
        if (beats.size() > bb) chk("t1_beat0", beats[bb].d, exp1);
        check_beats("t1", wb, 8, bb, 1'b0);

        // backpressure: held beat, full pack, reads stop
        do_reset();
        m_ready = 1'b0;
        wb = fifo_mem.size();
        bb = beats.size();
        for (int i = 0; i < 4; i++) push(32'h11 + i);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = m_valid;
        end
        chk("t2_valid", seen, 1'b1);
        d0 = m_data;
        tick();
        for (int i = 0; i < 5; i++) push(32'h15 + i);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!m_valid || m_data !== d0) stable = 1'b0;
            tick();
        end
        chk("t2_stable", stable, 1'b1);
        @(negedge clk);
        chk("t2_ren_stop", fifo_r_en, 1'b0);
        chk("t2_pops", rd_ptr - wb, 8);
        tick();
        m_ready = 1'b1;
        repeat (10) tick();
        pulse_flush();
        wait_done("t2_done");
        check_beats("t2", wb, 9, bb, 1'b1);

        // partial flush of three words
        do_reset();
        m_ready = 1'b1;
        wb = fifo_mem.size();
        bb = beats.size();
        push(32'hA);
        push(32'hB);
        push(32'hC);
        repeat (8) tick();
        pulse_flush();
        ren_drain = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (fifo_r_en) ren_drain++;
            seen = m_valid;
        end
        chk("t3_valid", seen, 1'b1);
        chk("t3_ren_drain", ren_drain, 0);
        chk("t3_done", flush_done, 1'b1);
        chk("t3_keep", m_keep, 4'h7);
        chk("t3_last", m_last, 1'b1);
        chk("t3_data", m_data, 128'h0_0000000C_0000000B_0000000A);
        @(negedge clk);
        chk("t3_done_pulse", flush_done, 1'b0);
        tick();

        // empty flush
        do_reset();
        bb = beats.size();
        flush = 1'b1;
        @(negedge clk);
        chk("t4_done_early", flush_done, 1'b0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t4_done", flush_done, 1'b1);
        chk("t4_valid", m_valid, 1'b0);
        @(negedge clk);
        chk("t4_done_pulse", flush_done, 1'b0);
        chk("t4_nobeat", beats.size() - bb, 0);
        tick();

        // reset mid-pack: two words captured, one in flight
        do_reset();
        m_ready = 1'b1;
        push(32'hDEAD0001);
        push(32'hDEAD0002);
        push(32'hDEAD0003);
        tick();
        tick();
        tick();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_r_en", fifo_r_en, 1'b0);
        chk("t5_valid", m_valid, 1'b0);
        chk("t5_data", m_data, '0);
        chk("t5_keep", m_keep, '0);
        chk("t5_last_done", {m_last, flush_done}, 2'b00);
        tick();
        rst = 1'b0;
        wb = fifo_mem.size();
        bb = beats.size();
        for (int i = 0; i < 4; i++) push(32'hC0DE0000 + i);
        repeat (12) tick();
        check_beats("t5", wb, 4, bb, 1'b0);

        // table-driven flush cases
        foreach (tbl[t]) begin
            do_reset();
            m_ready = 1'b1;
            wb = fifo_mem.size();
            bb = beats.size();
            for (int i = 0; i < tbl[t].n; i++) push($urandom);
            repeat (12) tick();
            pulse_flush();
            wait_done($sformatf("tbl%0d_done", t));
            repeat (2) tick();
            chk($sformatf("tbl%0d_nbeats", t), beats.size() - bb,
                tbl[t].nbeats);
            if (beats.size() > bb) begin
                chk($sformatf("tbl%0d_keep", t), beats[$].k, tbl[t].keep);
                chk($sformatf("tbl%0d_last", t), beats[$].l, tbl[t].last);
            end
            check_beats($sformatf("tbl%0d", t), wb, tbl[t].n, bb,
                        (tbl[t].n % PK) != 0);
        end

        // randomized stall/backpressure run
        do_reset();
        wb = fifo_mem.size();
        bb = beats.size();
        begin
            int pushed;
            int cyc;
            pushed = 0;
            cyc = 0;
            while (beats.size() - bb < 30 && cyc < 3000) begin
                tick();
                m_ready = 1'($urandom_range(0, 1));
                gate_empty = ($urandom_range(0, 3) == 0);
                if (pushed < 120 && $urandom_range(0, 2) != 0) begin
                    push($urandom);
                    pushed++;
                end
                cyc++;
            end
            chk("rand_timeout", cyc < 3000, 1'b1);
        end
        gate_empty = 1'b0;
        m_ready = 1'b1;
        repeat (4) tick();
        check_beats("rand", wb, 120, bb, 1'b0);

        chk("ren_while_empty", ren_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
